// File: rtl/glow_cell_ctrl_pkg.sv
// Shared definitions for the glow-in-the-dark byte cell controller.
// State encodings live here so the RAM interface and the debug display
// decode dbg_state identically.
package glow_cell_ctrl_pkg;

    // Width of the shared sequencing counter and of the refresh timer.
    localparam int CNT_W = 24;

    // Default timing for a 12 MHz clock.
    localparam int DEF_CHARGE_CYCLES  = 12_000_000;
    localparam int DEF_SETTLE_CYCLES  = 120_000;
    localparam int DEF_SAMPLE_GAP     = 1_200;
    localparam int DEF_REFRESH_CYCLES = 12_000_000;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SETTLE = 4'd1,
        ST_SAMPLE = 4'd2,
        ST_DONE   = 4'd3,
        ST_CHARGE = 4'd4
    } glow_state_t;

endpackage

// File: rtl/glow_cell_ctrl_if.sv
// Host-side request/response bundle between the bus RAM interface and the
// glow cell controller.
//
// Handshake: wr_req/rd_req are level requests taken by the controller on any
// clk edge where busy=0; a request seen while busy=1 is dropped, never
// queued. wr_req beats rd_req on the same edge. rd_valid is a one-cycle
// pulse marking a new host read result on rd_data; rd_data then holds until
// the next completed read or refresh.
interface glow_cell_ctrl_if;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output wr_req, wr_data, rd_req,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_data, rd_req,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/glow_cell_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous phototransistor levels.
module glow_cell_ctrl_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; the first may go metastable, the second settles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/glow_cell_ctrl.sv
// Physical-cell controller for the glow-in-the-dark memory byte.
// Writes charge LEDs for a fixed time; reads let the cells settle in the
// dark, take three spaced phototransistor samples and majority-vote them.
// An idle timer triggers a read-then-recharge refresh so stored 1s persist.
module glow_cell_ctrl
    import glow_cell_ctrl_pkg::*;
#(
    parameter int CHARGE_CYCLES  = DEF_CHARGE_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_GAP     = DEF_SAMPLE_GAP,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    glow_cell_ctrl_if.slave        bus,
    output logic [7:0]             glow_leds,
    input  logic [7:0]             glow_value,
    output logic [3:0]             dbg_state
);

    // Terminal counts: a phase of N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(SAMPLE_GAP - 1);
    localparam logic [CNT_W-1:0] REFRESH_TOP = CNT_W'(REFRESH_CYCLES);

    glow_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] refresh_timer;
    logic             refresh_flag;
    logic [1:0]       sample_idx;
    logic [7:0]       vote0;
    logic [7:0]       vote1;
    logic [7:0]       glow_sync;
    logic [7:0]       vote_result;
    logic             busy_q;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic [7:0]       leds_q;

    glow_cell_ctrl_sync #(.WIDTH(8)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (glow_value),
        .q     (glow_sync)
    );

    // Per-bit 2-of-3 vote; the third sample is the live synchronized value.
    assign vote_result = (vote0 & vote1) | (vote0 & glow_sync) | (vote1 & glow_sync);

    assign bus.busy     = busy_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign glow_leds    = leds_q;
    assign dbg_state    = state;

    // Sequencer: request arbitration, phase timing, sampling and refresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            refresh_timer <= '0;
            refresh_flag  <= 1'b0;
            sample_idx    <= 2'd0;
            vote0         <= '0;
            vote1         <= '0;
            busy_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            leds_q        <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Host requests beat a due refresh, which then stays pending.
                    if (bus.wr_req) begin
                        state        <= ST_CHARGE;
                        leds_q       <= bus.wr_data;
                        cnt          <= '0;
                        busy_q       <= 1'b1;
                        refresh_flag <= 1'b0;
                    end else if (bus.rd_req) begin
                        state        <= ST_SETTLE;
                        leds_q       <= '0;
                        cnt          <= '0;
                        busy_q       <= 1'b1;
                        refresh_flag <= 1'b0;
                    end else if (refresh_timer == REFRESH_TOP) begin
                        state        <= ST_SETTLE;
                        leds_q       <= '0;
                        cnt          <= '0;
                        busy_q       <= 1'b1;
                        refresh_flag <= 1'b1;
                    end
                    // Saturate so a deferred refresh is still due next idle cycle.
                    if (refresh_timer != REFRESH_TOP) begin
                        refresh_timer <= refresh_timer + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state      <= ST_SAMPLE;
                        cnt        <= '0;
                        sample_idx <= 2'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    // One sample on the last cycle of each gap window.
                    if (cnt == GAP_LAST) begin
                        cnt        <= '0;
                        sample_idx <= sample_idx + 2'd1;
                        case (sample_idx)
                            2'd0:    vote0 <= glow_sync;
                            2'd1:    vote1 <= glow_sync;
                            default: begin
                                state      <= ST_DONE;
                                rd_data_q  <= vote_result;
                                rd_valid_q <= ~refresh_flag;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // A refresh rewrites what it just read back.
                    if (refresh_flag) begin
                        state        <= ST_CHARGE;
                        leds_q       <= rd_data_q;
                        cnt          <= '0;
                        refresh_flag <= 1'b0;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                ST_CHARGE: begin
                    if (cnt == CHARGE_LAST) begin
                        state         <= ST_IDLE;
                        leds_q        <= '0;
                        busy_q        <= 1'b0;
                        refresh_timer <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    leds_q <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glow_cell_ctrl.sv
// Directed bench for glow_cell_ctrl with short timing constants.
// Read results flow through an expected queue checked by a monitor on
// rd_valid; LED/busy windows are checked cycle by cycle by the drivers.
module tb_glow_cell_ctrl;
    import glow_cell_ctrl_pkg::*;

    localparam int CHG = 8;
    localparam int STL = 4;
    localparam int GAP = 2;
    localparam int RFR = 64;
    // Edges after an accepted read until the DONE cycle begins.
    localparam int RD_DONE = STL + 3 * GAP;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] glow_leds;
    logic [7:0] glow_value;
    logic [3:0] dbg_state;

    glow_cell_ctrl_if bus_if ();

    glow_cell_ctrl #(
        .CHARGE_CYCLES  (CHG),
        .SETTLE_CYCLES  (STL),
        .SAMPLE_GAP     (GAP),
        .REFRESH_CYCLES (RFR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .glow_leds  (glow_leds),
        .glow_value (glow_value),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus_if.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_valid_unexpected: got pulse with rd_data 0x%0h expected no pulse",
                         bus_if.rd_data);
            end else begin
                check("sb_rd_data", bus_if.rd_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write d; optionally raise rd_req on the accept edge or pulse it mid-charge.
    task automatic do_write(input logic [7:0] d, input bit with_rd, input bit poke_rd,
                            input string tag);
        bus_if.wr_req  = 1'b1;
        bus_if.wr_data = d;
        bus_if.rd_req  = with_rd;
        step();
        bus_if.wr_req = 1'b0;
        bus_if.rd_req = 1'b0;
        for (int k = 1; k <= CHG; k++) begin
            check({tag, "_leds"}, glow_leds, d);
            check({tag, "_busy"}, bus_if.busy, 1'b1);
            if (k == 1) check({tag, "_state"}, dbg_state, ST_CHARGE);
            bus_if.rd_req = poke_rd && (k == 3);
            step();
        end
        bus_if.rd_req = 1'b0;
        check({tag, "_leds_end"}, glow_leds, 8'h00);
        check({tag, "_busy_end"}, bus_if.busy, 1'b0);
        check({tag, "_state_end"}, dbg_state, ST_IDLE);
    endtask

    // Host read with per-sample-window glow levels p0/p1/p2.
    task automatic do_read(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] exp, input string tag);
        glow_value    = p0;
        bus_if.rd_req = 1'b1;
        exp_q.push_back(exp);
        step();
        bus_if.rd_req = 1'b0;
        for (int k = 1; k <= RD_DONE + 1; k++) begin
            check({tag, "_leds_dark"}, glow_leds, 8'h00);
            check({tag, "_busy"}, bus_if.busy, 1'b1);
            check({tag, "_rd_valid"}, bus_if.rd_valid, (k == RD_DONE + 1));
            if (k < STL + GAP)          glow_value = p0;
            else if (k < STL + 2 * GAP) glow_value = p1;
            else                        glow_value = p2;
            step();
        end
        check({tag, "_busy_end"}, bus_if.busy, 1'b0);
        check({tag, "_rd_data_hold"}, bus_if.rd_data, exp);
    endtask

    // Wait (bounded) for busy to rise; returns idle edges seen.
    task automatic wait_busy(output int n);
        n = 0;
        while (bus_if.busy !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus_if.busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_idle_reached"}, bus_if.busy, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  n;
        bit  seen;
        reset          = 1'b1;
        bus_if.wr_req  = 1'b0;
        bus_if.wr_data = 8'h00;
        bus_if.rd_req  = 1'b0;
        glow_value     = 8'h00;

        repeat (3) step();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_leds", glow_leds, 8'h00);
        check("rst_rd_data", bus_if.rd_data, 8'h00);
        check("rst_rd_valid", bus_if.rd_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Basic write and steady read.
        do_write(8'hA5, 1'b0, 1'b0, "wr_a5");
        do_read(8'h3C, 8'h3C, 8'h3C, 8'h3C, "rd_3c");

        // Majority vote on bit0.
        do_read(8'h81, 8'h80, 8'h80, 8'h80, "vote_one");
        do_read(8'h81, 8'h80, 8'h81, 8'h81, "vote_two");

        // Write beats a simultaneous read; a mid-write read pulse is ignored.
        do_write(8'h0F, 1'b1, 1'b0, "arb");
        step();
        check("arb_no_read", bus_if.busy, 1'b0);
        do_write(8'hC3, 1'b0, 1'b1, "poke");
        step();
        check("poke_no_read", bus_if.busy, 1'b0);

        // An all-zero charge still runs full length and restarts the timer.
        do_write(8'h00, 1'b0, 1'b0, "wr_zero");

        // Refresh: timer reaches 64 after 64 idle edges, launch on the next.
        glow_value = 8'h55;
        wait_busy(n);
        check("refresh1_idle_edges", n, RFR + 1);
        check("refresh1_state", dbg_state, ST_SETTLE);
        for (int k = 1; k <= RD_DONE + 1; k++) begin
            check("refresh1_dark", glow_leds, 8'h00);
            check("refresh1_no_valid", bus_if.rd_valid, 1'b0);
            step();
        end
        check("refresh1_rd_data", bus_if.rd_data, 8'h55);
        for (int k = 1; k <= CHG; k++) begin
            check("refresh1_leds", glow_leds, 8'h55);
            check("refresh1_busy", bus_if.busy, 1'b1);
            step();
        end
        check("refresh1_leds_end", glow_leds, 8'h00);
        check("refresh1_busy_end", bus_if.busy, 1'b0);

        // Timer restarted at the end of the refresh charge.
        wait_busy(n);
        check("refresh2_idle_edges", n, RFR + 1);
        wait_idle("refresh2");

        // rd_req arriving exactly when refresh is due: the host read goes first.
        repeat (RFR) step();
        check("pre_collide_idle", bus_if.busy, 1'b0);
        do_read(8'h5A, 8'h5A, 8'h5A, 8'h5A, "rd_vs_refresh");
        step();
        check("deferred_refresh_busy", bus_if.busy, 1'b1);
        seen = 1'b0;
        n    = 0;
        while (bus_if.busy === 1'b1 && n < 200) begin
            if (glow_leds == 8'h5A) seen = 1'b1;
            step();
            n++;
        end
        check("deferred_refresh_leds", seen, 1'b1);
        check("deferred_refresh_done", bus_if.busy, 1'b0);

        // Asynchronous reset mid-charge.
        bus_if.wr_req  = 1'b1;
        bus_if.wr_data = 8'hFF;
        step();
        bus_if.wr_req = 1'b0;
        step();
        step();
        check("pre_reset_leds", glow_leds, 8'hFF);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_leds", glow_leds, 8'h00);
        check("async_rst_busy", bus_if.busy, 1'b0);
        check("async_rst_rd_data", bus_if.rd_data, 8'h00);
        check("async_rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        reset = 1'b0;
        step();
        do_write(8'h3C, 1'b0, 1'b0, "post_reset");

        repeat (2) step();
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glow_cell_ctrl.md
# glow_cell_ctrl

Physical-cell controller for the glow-in-the-dark byte of memory. Sits directly downstream of the bus-side RAM interface and consumes its byte write and read requests. It drives the 8 charge LEDs and samples the 8 phototransistors, using timed charge/settle/sample sequencing and 3-sample majority voting. It also performs periodic self-refresh so that stored 1-bits do not fade out.

## Interface
Parameters:
- CHARGE_CYCLES, 12_000_000: cycles LEDs stay lit for a write or refresh charge.
- SETTLE_CYCLES, 120_000: dark cycles after LEDs go off before sampling; must be >= 2.
- SAMPLE_GAP, 1_200: cycles between successive phototransistor samples.
- REFRESH_CYCLES, 12_000_000: idle cycles before an automatic refresh.
- All parameters must be >= 1 and <= 2^24-1. The shared cycle counter is 24 bits wide.

Ports:
- clk  in  1  system clock (iceFUN 12 MHz)
- reset  in  1  asynchronous, active-high reset
- wr_req  in  1  write request, sampled when busy=0
- wr_data  in  8  byte to store; 1 = charge that cell
- rd_req  in  1  read request, sampled when busy=0
- busy  out  1  controller is running a sequence
- rd_data  out  8  last read result
- rd_valid  out  1  one-cycle pulse when rd_data updates from a host read
- glow_leds  out  8  LED drive; 1 = LED on
- glow_value  in  8  raw phototransistor levels (asynchronous); 1 = glowing
- dbg_state  out  4  current state encoding

## Operation
- Reset values: state IDLE, busy=0, glow_leds=0, rd_data=0, rd_valid=0, refresh timer=0, sample votes=0.
- glow_value passes through a 2-flop synchronizer before any use.
- Request is accepted only on a clk edge where busy=0.
- If wr_req and rd_req are both high, the write wins and the read is dropped (not queued).
- Requests arriving while busy=1 are ignored.
- States:
  - IDLE → CHARGE on accepted write; glow_leds is loaded with wr_data.
  - IDLE → SETTLE on accepted read.
  - IDLE → SETTLE with the refresh flag set when the refresh timer reaches REFRESH_CYCLES and no request is present. If a request is present that cycle, the request wins and the refresh stays pending.
  - SETTLE: glow_leds=0 for SETTLE_CYCLES cycles, then → SAMPLE.
  - SAMPLE: three samples, each taken on the last cycle of a SAMPLE_GAP window. Result is per-bit majority of the 3 samples. Then → DONE.
  - DONE (1 cycle): rd_data = majority result.
    - Host read: rd_valid=1, then → IDLE.
    - Refresh: rd_valid=0, glow_leds loaded with the result, then → CHARGE.
  - CHARGE: glow_leds held for CHARGE_CYCLES cycles, then glow_leds=0 → IDLE.
- Writes cannot erase: 0-bits are simply not charged and decay naturally.
- A charge always runs its full length, including when the data is 0x00.
- Refresh timer:
  - Counts IDLE cycles.
  - Clears at the end of any CHARGE (write or refresh).
  - Host reads do not clear it.
  - Saturates at REFRESH_CYCLES while a refresh is pending.
- busy=1 in every state except IDLE.
- An asynchronous reset in any state returns immediately to the reset values, with LEDs off. The aborted operation is lost.

## Timing
- Write accepted at edge T: glow_leds=wr_data and busy=1 during cycles T+1..T+CHARGE_CYCLES; IDLE and busy=0 at T+CHARGE_CYCLES+1.
- Read accepted at edge T:
  - SETTLE occupies T+1..T+SETTLE_CYCLES.
  - SAMPLE occupies the next 3*SAMPLE_GAP cycles.
  - rd_valid=1 at cycle T+SETTLE_CYCLES+3*SAMPLE_GAP+1.
  - busy=0 on the following cycle.
- rd_data holds its value until the next DONE.
- Input-to-sample latency is 2 cycles from the synchronizer; SETTLE_CYCLES >= 2 covers it.

## Structure
- Shared include glow_pkg.vh: state encodings (IDLE, SETTLE, SAMPLE, DONE, CHARGE), counter width 24, and the default timing constants, so the RAM interface and top-level debug display decode dbg_state identically.
- One sub-module: glow_sync, an 8-bit two-flop synchronizer with async reset.
- The majority vote is inline combinational logic.

## Test plan
Use CHARGE=8, SETTLE=4, GAP=2, REFRESH=64.
- Write 0xA5 at T → glow_leds=0xA5 for T+1..T+8, busy=1 over the same window, glow_leds=0 and busy=0 at T+9.
- Read with glow_value steady 0x3C at T → glow_leds=0 throughout, rd_valid single pulse at T+11 with rd_data=0x3C.
- Read with bit0 high in sample 1 only and glow_value otherwise 0x80 → rd_data=0x80. Same read with bit0 high in two samples → rd_data=0x81.
- Arbitration and busy:
  - wr_req=1 and rd_req=1 on the same edge (wr_data=0x0F) → write sequence only, no rd_valid.
  - rd_req pulsed mid-write → ignored.
- Refresh:
  - 64 idle cycles with glow_value=0x55 → busy rises, no rd_valid, then glow_leds=0x55 for 8 cycles, then timer restarts.
  - rd_req on the cycle the refresh fires → host read runs first.
- Reset asserted mid-CHARGE → glow_leds=0, busy=0, rd_data=0 without waiting for a clk edge. Next write behaves normally.
